// File: rtl/loby_feeder_if.sv
// loby_feeder_if
//   Backpressured 32-bit message stream feeding the LoBy feeder.
//   master : upstream source (drives msg_data/msg_valid/msg_last, sees msg_ready)
//   slave  : loby_feeder (sees msg_data/msg_valid/msg_last, drives msg_ready)
//   A word transfers on a rising clock edge where msg_valid & msg_ready.
//   msg_last marks the final word of a job and is qualified by msg_valid.
interface loby_feeder_if;
  logic [31:0] msg_data;
  logic        msg_valid;
  logic        msg_last;
  logic        msg_ready;

  modport master (output msg_data, output msg_valid, output msg_last, input msg_ready);
  modport slave  (input msg_data, input msg_valid, input msg_last, output msg_ready);
endinterface

// File: rtl/loby_feeder.sv
// loby_feeder
//   Upstream sequencer for the LoBy absorb/squeeze core. On start it latches
//   a 257-bit key and pulses init. It then packs 32-bit message words into
//   64-bit din blocks, with the first word of each pair in din[31:0]. It
//   appends the padding word, and finally holds sqz so the core squeezes out
//   its digest. Every pulse sent to the core is followed by a hold cycle.
//   During the hold cycle the pulse is low and key/din keep their values,
//   because the core consumes them one cycle after it registers the pulse.
//   All outputs are registered.
// Ports
//   clk        in   system clock, rising edge
//   arstn      in   asynchronous reset, active-high
//   start      in   begin a job (sampled only in IDLE)
//   key_in     in   257-bit key, captured when start is accepted
//   msg        if   message stream, slave side (loby_feeder_if.slave)
//   init       out  key load pulse to the core
//   key        out  latched key
//   din        out  64-bit message block
//   din_valid  out  absorb pulse
//   sqz        out  squeeze enable, held SQZ_CYCLES cycles
//   busy       out  high from start accept until back in IDLE
//   done       out  one-cycle pulse on the last squeeze cycle
// Build option
//   LOBY_FEED_LEN_EN : after the padding block, absorb one more block that
//                      holds the zero-extended word count before squeezing.
module loby_feeder #(
  parameter int          SQZ_CYCLES = 1,
  parameter logic [31:0] PAD_WORD   = 32'h00000001,
  parameter int          CNT_W      = 32
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          start,
  input  logic [256:0]  key_in,
  loby_feeder_if.slave  msg,
  output logic          init,
  output logic [256:0]  key,
  output logic [63:0]   din,
  output logic          din_valid,
  output logic          sqz,
  output logic          busy,
  output logic          done
);

  localparam int SQ_W = (SQZ_CYCLES > 1) ? $clog2(SQZ_CYCLES) : 1;
  localparam logic [SQ_W-1:0] SQZ_LAST = SQ_W'(SQZ_CYCLES - 1);

  // EMIT is the single absorb-pulse state. It covers data blocks, the padding
  // block and the length block. ret_reg says where to go after the hold.
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_INIT_H, S_LO, S_HI, S_EMIT, S_HOLD, S_SQZ
  } state_t;

  typedef enum logic [1:0] {RET_LO, RET_PADB, RET_LEN, RET_SQZ} ret_t;

  // What follows the block that carries the padding word.
`ifdef LOBY_FEED_LEN_EN
  localparam ret_t RET_TAIL = RET_LEN;
`else
  localparam ret_t RET_TAIL = RET_SQZ;
`endif

  state_t           state_reg;
  ret_t             ret_reg;
  logic [256:0]     key_q_reg;
  logic [63:0]      din_q_reg;
  logic [CNT_W-1:0] word_cnt_reg;
  logic [SQ_W-1:0]  sqz_cnt_reg;
  logic             init_reg;
  logic             din_valid_reg;
  logic             sqz_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             msg_ready_reg;

  logic             accept;
  logic [63:0]      len_blk;

  // msg_ready_reg is only ever high in LO/HI, so the handshake alone
  // qualifies a transfer.
  assign accept  = msg.msg_valid & msg_ready_reg;
  assign len_blk = 64'(word_cnt_reg);

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      state_reg     <= S_IDLE;
      ret_reg       <= RET_LO;
      key_q_reg     <= '0;
      din_q_reg     <= '0;
      word_cnt_reg  <= '0;
      sqz_cnt_reg   <= '0;
      init_reg      <= 1'b0;
      din_valid_reg <= 1'b0;
      sqz_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      msg_ready_reg <= 1'b0;
    end else begin
      // Pulses default low. Each one is raised only when its state is entered.
      init_reg      <= 1'b0;
      din_valid_reg <= 1'b0;
      done_reg      <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            key_q_reg    <= key_in;
            word_cnt_reg <= '0;
            init_reg     <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= S_INIT;
          end
        end

        S_INIT:   state_reg <= S_INIT_H;

        S_INIT_H: begin
          msg_ready_reg <= 1'b1;
          state_reg     <= S_LO;
        end

        S_LO: begin
          if (accept) begin
            din_q_reg[31:0] <= msg.msg_data;
            word_cnt_reg    <= word_cnt_reg + CNT_W'(1);
            if (msg.msg_last) begin
              // Odd word count: the pad fills the upper half of this block.
              din_q_reg[63:32] <= PAD_WORD;
              msg_ready_reg    <= 1'b0;
              din_valid_reg    <= 1'b1;
              ret_reg          <= RET_TAIL;
              state_reg        <= S_EMIT;
            end else begin
              state_reg <= S_HI;
            end
          end
        end

        S_HI: begin
          if (accept) begin
            din_q_reg[63:32] <= msg.msg_data;
            word_cnt_reg     <= word_cnt_reg + CNT_W'(1);
            msg_ready_reg    <= 1'b0;
            din_valid_reg    <= 1'b1;
            // Even word count: a separate padding block must follow.
            ret_reg          <= msg.msg_last ? RET_PADB : RET_LO;
            state_reg        <= S_EMIT;
          end
        end

        S_EMIT: state_reg <= S_HOLD;

        S_HOLD: begin
          case (ret_reg)
            RET_LO: begin
              msg_ready_reg <= 1'b1;
              state_reg     <= S_LO;
            end
            RET_PADB: begin
              din_q_reg     <= {32'h0, PAD_WORD};
              din_valid_reg <= 1'b1;
              ret_reg       <= RET_TAIL;
              state_reg     <= S_EMIT;
            end
            RET_LEN: begin
              din_q_reg     <= len_blk;
              din_valid_reg <= 1'b1;
              ret_reg       <= RET_SQZ;
              state_reg     <= S_EMIT;
            end
            default: begin
              sqz_reg     <= 1'b1;
              sqz_cnt_reg <= '0;
              done_reg    <= (SQZ_CYCLES == 1);
              state_reg   <= S_SQZ;
            end
          endcase
        end

        S_SQZ: begin
          if (sqz_cnt_reg == SQZ_LAST) begin
            sqz_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            sqz_cnt_reg <= sqz_cnt_reg + 1'b1;
            done_reg    <= ((sqz_cnt_reg + 1'b1) == SQZ_LAST);
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign msg.msg_ready = msg_ready_reg;
  assign init          = init_reg;
  assign key           = key_q_reg;
  assign din           = din_q_reg;
  assign din_valid     = din_valid_reg;
  assign sqz           = sqz_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule
